rv32_decode_unit: RTL and testbench

RV32I decode/control block for the single-issue core: takes the fetched instruction word and produces every datapath select (ALU operands/op, register write, data-memory strobes, PC update mode), the sign-extended immediate and CSR read data. Holds the small state machine for two-cycle loads and the 64-bit cycle/instret counters. Sits between instruction memory and the register file/ALU/memory encoder.

---
 rtl/rv32_decode_unit.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_rv32_decode_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_decode_unit.sv
// rv32_decode_unit
//   RV32I decode/control for the single-issue core. Turns the fetched
//   instruction word into datapath selects, the sign-extended immediate and
//   CSR read data. It also holds the two-cycle load sequencer and the 64-bit
//   cycle/instret counters.
//
//   Build option: CTRL_MUL_EN -- when defined, OP with funct7 0x01 decodes as
//   an M-extension multiply (alu_mul=1). When undefined, alu_mul stays 0 and
//   that encoding is illegal.
//
//   Ports:
//     clk        core clock, rising edge
//     reset_n    asynchronous active-low reset
//     ins        current instruction word
//     op_illegal instruction not decodable
//     alu_op     ALU function (RV32I funct3 numbering)
//     alu_alt    sub/sra select
//     alu_imm    ALU B = imm (else rs2)
//     alu_a0     ALU A = 0
//     alu_apc    ALU A = pc
//     alu_b4     ALU B = 4 (overrides alu_imm)
//     alu_mul    writeback from multiplier
//     reg_wen    write rd
//     pc_imm     PC mode: 0 hold, 1 +4, 2 br-if-nz, 3 br-if-z, 4 pc+imm, 5 rs1+imm
//     dmem_read  load address phase
//     dmem_reg   writeback from load data
//     dmem_write store
//     csr_reg    writeback from csr_rdata
//     stage0     first (or only) cycle of instruction
//     imm        immediate
//     csr_rdata  CSR read value (address ins[31:20])
module rv32_decode_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ins,
    output logic        op_illegal,
    output logic [2:0]  alu_op,
    output logic        alu_alt,
    output logic        alu_imm,
    output logic        alu_a0,
    output logic        alu_apc,
    output logic        alu_b4,
    output logic        alu_mul,
    output logic        reg_wen,
    output logic [2:0]  pc_imm,
    output logic        dmem_read,
    output logic        dmem_reg,
    output logic        dmem_write,
    output logic        csr_reg,
    output logic        stage0,
    output logic [31:0] imm,
    output logic [31:0] csr_rdata
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic {
        ST_FIRST,
        ST_SECOND
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] cycle;
    logic [63:0] instret;
    logic        illegal;
    logic        load_first;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ins[6:0];
    assign funct3 = ins[14:12];
    assign funct7 = ins[31:25];

    // Immediate, selected by instruction format.
    always_comb begin
        imm = '0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR:
                imm = {{20{ins[31]}}, ins[31:20]};
            OPC_STORE:
                imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OPC_BRANCH:
                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {ins[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    // Control decode. The opcode case sets the flags and raises 'illegal'.
    // An illegal instruction then clears every flag. Reset overrides last.
    always_comb begin
        op_illegal = 1'b0;
        alu_op     = 3'd0;
        alu_alt    = 1'b0;
        alu_imm    = 1'b0;
        alu_a0     = 1'b0;
        alu_apc    = 1'b0;
        alu_b4     = 1'b0;
        alu_mul    = 1'b0;
        reg_wen    = 1'b0;
        pc_imm     = 3'd1;
        dmem_read  = 1'b0;
        dmem_reg   = 1'b0;
        dmem_write = 1'b0;
        csr_reg    = 1'b0;
        stage0     = (state == ST_FIRST);
        illegal    = 1'b0;
        load_first = 1'b0;

        case (opcode)
            OPC_LUI: begin
                alu_a0  = 1'b1;
                alu_imm = 1'b1;
                reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                alu_apc = 1'b1;
                alu_imm = 1'b1;
                reg_wen = 1'b1;
            end
            OPC_JAL: begin
                alu_apc = 1'b1;
                alu_b4  = 1'b1;
                reg_wen = 1'b1;
                pc_imm  = 3'd4;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    alu_apc = 1'b1;
                    alu_b4  = 1'b1;
                    reg_wen = 1'b1;
                    pc_imm  = 3'd5;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                // Equality uses sub (zero test); ordering uses slt/sltu result.
                case (funct3)
                    3'b000: begin alu_alt = 1'b1; pc_imm = 3'd3; end
                    3'b001: begin alu_alt = 1'b1; pc_imm = 3'd2; end
                    3'b100: begin alu_op = 3'd2;  pc_imm = 3'd2; end
                    3'b101: begin alu_op = 3'd2;  pc_imm = 3'd3; end
                    3'b110: begin alu_op = 3'd3;  pc_imm = 3'd2; end
                    3'b111: begin alu_op = 3'd3;  pc_imm = 3'd3; end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                    funct3 == 3'b100 || funct3 == 3'b101) begin
                    alu_imm   = 1'b1;
                    dmem_read = 1'b1;
                    if (state == ST_FIRST) begin
                        pc_imm     = 3'd0;
                        load_first = 1'b1;
                    end else begin
                        dmem_reg = 1'b1;
                        reg_wen  = 1'b1;
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
                    alu_imm    = 1'b1;
                    dmem_write = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                alu_imm = 1'b1;
                alu_op  = funct3;
                reg_wen = 1'b1;
                if (funct3 == 3'b001) begin
                    if (funct7 != 7'h00) illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    alu_alt = ins[30];
                    if (funct7 != 7'h00 && funct7 != 7'h20) illegal = 1'b1;
                end
            end
            OPC_OP: begin
                alu_op  = funct3;
                reg_wen = 1'b1;
                if (funct7 == 7'h00) begin
                    alu_alt = 1'b0;
                end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    alu_alt = 1'b1;
`ifdef CTRL_MUL_EN
                end else if (funct7 == 7'h01) begin
                    alu_mul = 1'b1;
`endif
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_FENCE: begin
                pc_imm = 3'd1;
            end
            OPC_SYSTEM: begin
                // ECALL/EBREAK are NOPs; CSR ops only read, writes are dropped.
                if (funct3 != 3'b000) begin
                    csr_reg = 1'b1;
                    reg_wen = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            op_illegal = 1'b1;
            alu_op     = 3'd0;
            alu_alt    = 1'b0;
            alu_imm    = 1'b0;
            alu_a0     = 1'b0;
            alu_apc    = 1'b0;
            alu_b4     = 1'b0;
            alu_mul    = 1'b0;
            reg_wen    = 1'b0;
            pc_imm     = 3'd1;
            dmem_read  = 1'b0;
            dmem_reg   = 1'b0;
            dmem_write = 1'b0;
            csr_reg    = 1'b0;
        end

        if (!reset_n) begin
            reg_wen    = 1'b0;
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
            pc_imm     = 3'd0;
            stage0     = 1'b1;
        end
    end

    always_comb begin
        state_next = load_first ? ST_SECOND : ST_FIRST;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_FIRST;
            cycle   <= '0;
            instret <= '0;
        end else begin
            state <= state_next;
            cycle <= cycle + 64'd1;
            // Every cycle retires except the address phase of a load.
            if (!load_first) begin
                instret <= instret + 64'd1;
            end
        end
    end

    always_comb begin
        case (ins[31:20])
            12'hC00, 12'hC01: csr_rdata = cycle[31:0];
            12'hC80, 12'hC81: csr_rdata = cycle[63:32];
            12'hC02:          csr_rdata = instret[31:0];
            12'hC82:          csr_rdata = instret[63:32];
            default:          csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_rv32_decode_unit.sv
module tb_rv32_decode_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] ins;
    logic        op_illegal;
    logic [2:0]  alu_op;
    logic        alu_alt;
    logic        alu_imm;
    logic        alu_a0;
    logic        alu_apc;
    logic        alu_b4;
    logic        alu_mul;
    logic        reg_wen;
    logic [2:0]  pc_imm;
    logic        dmem_read;
    logic        dmem_reg;
    logic        dmem_write;
    logic        csr_reg;
    logic        stage0;
    logic [31:0] imm;
    logic [31:0] csr_rdata;

    int checks;
    int failures;

    rv32_decode_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ins        (ins),
        .op_illegal (op_illegal),
        .alu_op     (alu_op),
        .alu_alt    (alu_alt),
        .alu_imm    (alu_imm),
        .alu_a0     (alu_a0),
        .alu_apc    (alu_apc),
        .alu_b4     (alu_b4),
        .alu_mul    (alu_mul),
        .reg_wen    (reg_wen),
        .pc_imm     (pc_imm),
        .dmem_read  (dmem_read),
        .dmem_reg   (dmem_reg),
        .dmem_write (dmem_write),
        .csr_reg    (csr_reg),
        .stage0     (stage0),
        .imm        (imm),
        .csr_rdata  (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] RDCYCLE    = 32'hC0002573;
    localparam logic [31:0] RDCYCLEH   = 32'hC8002573;
    localparam logic [31:0] RDINSTRET  = 32'hC0202573;
    localparam logic [31:0] RDINSTRETH = 32'hC8202573;
    localparam logic [31:0] LW         = 32'h0040A103;
    localparam logic [31:0] SW         = 32'h0020A423;

    // Reference counters: cycle counts every edge out of reset; instret skips
    // the address phase of a load (the bench flags which instructions are loads).
    logic        tb_load;
    logic [63:0] m_cycle;
    logic [63:0] m_instret;
    logic        m_second;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cycle   <= '0;
            m_instret <= '0;
            m_second  <= 1'b0;
        end else begin
            m_cycle <= m_cycle + 64'd1;
            if (tb_load && !m_second) begin
                m_second <= 1'b1;
            end else begin
                m_second  <= 1'b0;
                m_instret <= m_instret + 64'd1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Packed control word: {ill, op, alt, imm, a0, apc, b4, mul, wen, pc, rd, dreg, wr, csr, s0}
    function automatic logic [18:0] mk(input logic ill, input logic [2:0] op, input logic alt,
                                       input logic im, input logic a0, input logic apc,
                                       input logic b4, input logic mul, input logic wen,
                                       input logic [2:0] pc, input logic rd, input logic dreg,
                                       input logic wr, input logic csr, input logic s0);
        return {ill, op, alt, im, a0, apc, b4, mul, wen, pc, rd, dreg, wr, csr, s0};
    endfunction

    function automatic logic [18:0] ctrl_now();
        return {op_illegal, alu_op, alu_alt, alu_imm, alu_a0, alu_apc, alu_b4, alu_mul,
                reg_wen, pc_imm, dmem_read, dmem_reg, dmem_write, csr_reg, stage0};
    endfunction

    typedef struct {
        string       tag;
        logic [31:0] ins;
        logic [18:0] ctrl;
        logic [31:0] imm;
        bit          chk_imm;
    } vec_t;

    vec_t        vecs[$];
    logic [18:0] ill_mask;
    logic [18:0] cmask;
    logic [31:0] v0;

    initial begin
        checks   = 0;
        failures = 0;
        tb_load  = 1'b0;
        reset_n  = 1'b0;
        ins      = 32'h00000013;
        ill_mask = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 3'd7, 1, 1, 1, 1, 0);

        // Reset state.
        @(negedge clk);
        #1;
        check_eq("rst_stage0", stage0, 1);
        check_eq("rst_pc_imm", pc_imm, 0);
        check_eq("rst_reg_wen", reg_wen, 0);

        // rdcycle ten edges after release.
        @(negedge clk);
        reset_n = 1'b1;
        ins     = RDCYCLE;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rdcycle10", csr_rdata, 32'd10);
        check_eq("rdcycle_csr_reg", csr_reg, 1);
        ins = 32'hC0102573;
        #1 check_eq("rdtime10", csr_rdata, 32'd10);
        ins = RDINSTRET;
        #1 check_eq("rdinstret10", csr_rdata, 32'd10);
        ins = RDCYCLEH;
        #1 check_eq("rdcycleh0", csr_rdata, 32'd0);
        ins = 32'hC0302573;
        #1 check_eq("csr_unmapped", csr_rdata, 32'd0);

        // Directed single-cycle decode vectors.
        vecs.push_back('{"addi",  32'h00500093, mk(0,0,0,1,0,0,0,0,1,3'd1,0,0,0,0,1), 32'h00000005, 1});
        vecs.push_back('{"lui",   32'h123450B7, mk(0,0,0,1,1,0,0,0,1,3'd1,0,0,0,0,1), 32'h12345000, 1});
        vecs.push_back('{"auipc", 32'h00001097, mk(0,0,0,1,0,1,0,0,1,3'd1,0,0,0,0,1), 32'h00001000, 1});
        vecs.push_back('{"beq",   32'hFE208EE3, mk(0,0,1,0,0,0,0,0,0,3'd3,0,0,0,0,1), 32'hFFFFFFFC, 1});
        vecs.push_back('{"bltu",  32'h0020E463, mk(0,3,0,0,0,0,0,0,0,3'd2,0,0,0,0,1), 32'h00000008, 1});
        vecs.push_back('{"jal",   32'h0000006F, mk(0,0,0,0,0,1,1,0,1,3'd4,0,0,0,0,1), 32'h00000000, 1});
        vecs.push_back('{"jalr",  32'h00008067, mk(0,0,0,0,0,1,1,0,1,3'd5,0,0,0,0,1), 32'h00000000, 1});
        vecs.push_back('{"sw",    SW,           mk(0,0,0,1,0,0,0,0,0,3'd1,0,0,1,0,1), 32'h00000008, 1});
        vecs.push_back('{"srai",  32'h4030D093, mk(0,5,1,1,0,0,0,0,1,3'd1,0,0,0,0,1), 32'h00000403, 1});
        vecs.push_back('{"sub",   32'h402081B3, mk(0,0,1,0,0,0,0,0,1,3'd1,0,0,0,0,1), 32'h00000000, 1});
        vecs.push_back('{"and",   32'h0020F1B3, mk(0,7,0,0,0,0,0,0,1,3'd1,0,0,0,0,1), 32'h00000000, 1});
        vecs.push_back('{"slli_bad", 32'h02009093, mk(1,0,0,0,0,0,0,0,0,3'd1,0,0,0,0,1), 32'h00000020, 1});
        vecs.push_back('{"br_f3_bad", 32'hFE20AEE3, mk(1,0,0,0,0,0,0,0,0,3'd1,0,0,0,0,1), 32'hFFFFFFFC, 1});
        vecs.push_back('{"all_ones", 32'hFFFFFFFF, mk(1,0,0,0,0,0,0,0,0,3'd1,0,0,0,0,1), 32'h00000000, 1});
        vecs.push_back('{"lb_f3_bad", 32'h0040B103, mk(1,0,0,0,0,0,0,0,0,3'd1,0,0,0,0,1), 32'h00000004, 1});
        vecs.push_back('{"ecall", 32'h00000073, mk(0,0,0,0,0,0,0,0,0,3'd1,0,0,0,0,1), 32'h00000000, 1});
        vecs.push_back('{"fence", 32'h0FF0000F, mk(0,0,0,0,0,0,0,0,0,3'd1,0,0,0,0,1), 32'h00000000, 0});
        vecs.push_back('{"rdcycle_ctl", RDCYCLE, mk(0,0,0,0,0,0,0,0,1,3'd1,0,0,0,1,1), 32'h00000000, 0});
`ifdef CTRL_MUL_EN
        vecs.push_back('{"mul",   32'h02208033, mk(0,0,0,0,0,0,0,1,1,3'd1,0,0,0,0,1), 32'h00000000, 1});
`else
        vecs.push_back('{"mul_off", 32'h02208033, mk(1,0,0,0,0,0,0,0,0,3'd1,0,0,0,0,1), 32'h00000000, 1});
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            ins = vecs[i].ins;
            #1;
            cmask = vecs[i].ctrl[18] ? ill_mask : '1;
            check_eq({vecs[i].tag, "_ctrl"}, ctrl_now() & cmask, vecs[i].ctrl & cmask);
            if (vecs[i].chk_imm)
                check_eq({vecs[i].tag, "_imm"}, imm, vecs[i].imm);
        end

        // Two-cycle load; instret advances once across both cycles.
        @(negedge clk);
        ins = RDINSTRET;
        #1;
        v0 = csr_rdata;
        check_eq("instret_model", csr_rdata, m_instret[31:0]);
        ins     = LW;
        tb_load = 1'b1;
        #1;
        check_eq("lw_c1_ctrl", ctrl_now(), mk(0,0,0,1,0,0,0,0,0,3'd0,1,0,0,0,1));
        check_eq("lw_imm", imm, 32'h4);
        @(negedge clk);
        #1;
        check_eq("lw_c2_ctrl", ctrl_now(), mk(0,0,0,1,0,0,0,0,1,3'd1,1,1,0,0,0));
        tb_load = 1'b0;
        ins     = RDINSTRET;
        @(negedge clk);
        #1;
        check_eq("lw_instret_plus1", csr_rdata, v0 + 32'd1);
        ins = RDCYCLE;
        #1 check_eq("cycle_model", csr_rdata, m_cycle[31:0]);
        ins = RDINSTRETH;
        #1 check_eq("instreth_model", csr_rdata, m_instret[63:32]);

        // Reset asserted during the second cycle of a load.
        @(negedge clk);
        ins     = LW;
        tb_load = 1'b1;
        @(negedge clk);
        #1;
        check_eq("midload_stage0", stage0, 0);
        reset_n = 1'b0;
        #1;
        check_eq("rst_midload_stage0", stage0, 1);
        check_eq("rst_midload_wen", reg_wen, 0);
        check_eq("rst_midload_read", dmem_read, 0);
        check_eq("rst_midload_pc", pc_imm, 0);
        tb_load = 1'b0;
        ins = RDCYCLE;
        #1 check_eq("rst_cycle0", csr_rdata, 0);
        check_eq("rst_csr_wen", reg_wen, 0);
        ins = RDINSTRET;
        #1 check_eq("rst_instret0", csr_rdata, 0);
        ins = SW;
        #1 check_eq("rst_sw_write", dmem_write, 0);

        // First edge after release counts.
        @(negedge clk);
        reset_n = 1'b1;
        ins     = RDCYCLE;
        @(negedge clk);
        #1;
        check_eq("post_rst_cycle1", csr_rdata, 32'd1);
        check_eq("post_rst_stage0", stage0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
